// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with a 2-entry
// output buffer (main register + skid register).
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both 1 on that edge. A producer holds its payload stable while valid=1
// and ready=0. in_ready is a function of registered state only, so there is
// no combinational path from out_ready to in_ready.
//
// Parameters:
//   XLEN     immediate width, 32 or 64
//   SHAMT_W  shift-amount width, 5 for XLEN=32, 6 for XLEN=64
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (highest priority)
//   flush        synchronous kill of all buffered entries and any input
//   in_valid     instr/imm_sel valid
//   in_ready     block can accept an input (states EMPTY, ONE)
//   instr        raw 32-bit instruction word
//   imm_sel      000 I, 001 S, 010 B, 011 U, 100 J, 101 SHIFT, 110 SRA,
//                111 illegal
//   out_valid    imm_out/out_illegal valid (states ONE, FULL)
//   out_ready    downstream accepts the output
//   imm_out      decoded immediate
//   out_illegal  the entry carried imm_sel=111
//   state_q      internal FSM state, kept as a named signal for probing
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Entry layout: {illegal, immediate}
  logic [XLEN:0]   main_q, main_d;
  logic [XLEN:0]   skid_q, skid_d;
  logic [XLEN:0]   dec_entry;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  logic            in_xfer;
  logic            out_xfer;

  // The opcode field never contributes to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Decode. Size casts of signed operands sign-extend from instr[31];
  // the shift amount is cast from an unsigned slice, so it zero-extends.
  always_comb begin
    dec_imm = '0;
    dec_ill = 1'b0;
    case (imm_sel)
      3'b000: dec_imm = XLEN'($signed(instr[31:20]));
      3'b001: dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      3'b010: dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                       instr[11:8], 1'b0}));
      3'b011: dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
      3'b100: dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                       instr[30:21], 1'b0}));
      3'b101: dec_imm = XLEN'(instr[20 +: SHAMT_W]);
      3'b110: dec_imm = XLEN'(instr[20 +: SHAMT_W]) | XLEN'(11'h400);
      default: begin
        dec_imm = '0;
        dec_ill = 1'b1;
      end
    endcase
  end

  assign dec_entry = {dec_ill, dec_imm};

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Next-state and buffer steering. The main register always holds the
  // oldest entry; the skid register only fills when ONE receives an input
  // without draining, which keeps acceptance order intact.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = dec_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d  = dec_entry;
        end else if (in_xfer) begin
          skid_d  = dec_entry;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides every transfer decided above.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign imm_out     = main_q[XLEN-1:0];
  assign out_illegal = main_q[XLEN];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance
// driven by the same inputs, checked against hand-computed values.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, ill_a;
  logic [31:0] imm_a;
  logic        in_ready_b, out_valid_b, ill_b;
  logic [63:0] imm_b;

  int n_cmp;
  int n_err;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SHAMT_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(instr), .imm_sel(imm_sel),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .imm_out(imm_a), .out_illegal(ill_a)
  );

  imm_gen_pipe #(.XLEN(64), .SHAMT_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .instr(instr), .imm_sel(imm_sel),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .imm_out(imm_b), .out_illegal(ill_b)
  );

  // Driver tasks
  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks both instances' handshake outputs together.
  task automatic chk_hs(input string tag, input logic exp_ov,
                        input logic exp_ir);
    chk({tag, "_ov32"}, 64'(out_valid_a), 64'(exp_ov));
    chk({tag, "_ov64"}, 64'(out_valid_b), 64'(exp_ov));
    chk({tag, "_ir32"}, 64'(in_ready_a), 64'(exp_ir));
    chk({tag, "_ir64"}, 64'(in_ready_b), 64'(exp_ir));
  endtask

  task automatic chk_data(input string tag, input logic [31:0] e32,
                          input logic [63:0] e64, input logic e_ill);
    chk({tag, "_imm32"}, 64'(imm_a), 64'(e32));
    chk({tag, "_imm64"}, imm_b, e64);
    chk({tag, "_ill32"}, 64'(ill_a), 64'(e_ill));
    chk({tag, "_ill64"}, 64'(ill_b), 64'(e_ill));
  endtask

  // One input with out_ready=1: visible one edge later, drained the next.
  task automatic send_one(input string tag, input logic [2:0] sel,
                          input logic [31:0] ins, input logic [31:0] e32,
                          input logic [63:0] e64, input logic e_ill);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    imm_sel   = sel;
    instr     = ins;
    step();
    in_valid  = 1'b0;
    chk_hs({tag, "_lat"}, 1'b1, 1'b1);
    chk_data(tag, e32, e64, e_ill);
    step();
    chk_hs({tag, "_drain"}, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [31:0] ins);
    in_valid = 1'b1;
    imm_sel  = 3'b000;
    instr    = ins;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    imm_sel   = '0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    chk_hs("reset", 1'b0, 1'b1);
    chk_data("reset", 32'h0, 64'h0, 1'b0);

    // Decode vectors (XLEN=32 / XLEN=64 expectations)
    send_one("i_neg1", 3'b000, 32'hFFF00093, 32'hFFFFFFFF,
             64'hFFFFFFFFFFFFFFFF, 1'b0);
    send_one("i_max", 3'b000, 32'h7FF00093, 32'h000007FF,
             64'h00000000000007FF, 1'b0);
    send_one("s_12", 3'b001, 32'h00112623, 32'h0000000C,
             64'h000000000000000C, 1'b0);
    send_one("b_neg4", 3'b010, 32'hFE000EE3, 32'hFFFFFFFC,
             64'hFFFFFFFFFFFFFFFC, 1'b0);
    send_one("u_neg", 3'b011, 32'h800000B7, 32'h80000000,
             64'hFFFFFFFF80000000, 1'b0);
    send_one("j_pos8", 3'b100, 32'h0080006F, 32'h00000008,
             64'h0000000000000008, 1'b0);
    send_one("j_neg4", 3'b100, 32'hFFDFF06F, 32'hFFFFFFFC,
             64'hFFFFFFFFFFFFFFFC, 1'b0);
    send_one("shift", 3'b101, 32'h43F0D093, 32'h0000001F,
             64'h000000000000003F, 1'b0);
    send_one("sra", 3'b110, 32'h43F0D093, 32'h0000041F,
             64'h000000000000043F, 1'b0);
    send_one("illegal", 3'b111, 32'hFFFFFFFF, 32'h0,
             64'h0, 1'b1);

    // Backpressure: A, B accepted, C held off until space frees
    out_ready = 1'b0;
    chk_hs("bp_pre", 1'b0, 1'b1);
    in_valid = 1'b1;
    imm_sel  = 3'b000;
    instr    = 32'h00100093;              // A = 1
    step();
    chk_hs("bp_a", 1'b1, 1'b1);
    instr    = 32'h00200093;              // B = 2
    step();
    chk_hs("bp_full", 1'b1, 1'b0);
    chk_data("bp_head", 32'd1, 64'd1, 1'b0);
    instr    = 32'h00300093;              // C = 3, offered while full
    step();
    chk_hs("bp_stall1", 1'b1, 1'b0);
    chk_data("bp_stall1", 32'd1, 64'd1, 1'b0);
    step();
    chk_hs("bp_stall2", 1'b1, 1'b0);
    chk_data("bp_stall2", 32'd1, 64'd1, 1'b0);
    out_ready = 1'b1;
    step();                               // A leaves, B moves to main
    chk_hs("bp_b", 1'b1, 1'b1);
    chk_data("bp_b", 32'd2, 64'd2, 1'b0);
    step();                               // B leaves, C accepted
    in_valid = 1'b0;
    chk_hs("bp_c", 1'b1, 1'b1);
    chk_data("bp_c", 32'd3, 64'd3, 1'b0);
    step();                               // C leaves
    chk_hs("bp_empty", 1'b0, 1'b1);

    // Flush in FULL with simultaneous input and output
    out_ready = 1'b0;
    push(32'h00400093);
    push(32'h00500093);
    chk_hs("fl_full", 1'b1, 1'b0);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'h00600093;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    chk_hs("fl_after", 1'b0, 1'b1);
    step();
    chk_hs("fl_dropped", 1'b0, 1'b1);

    // Reset mid-stream while FULL
    out_ready = 1'b0;
    push(32'h00700093);
    push(32'h00800093);
    chk_hs("rs_full", 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_hs("rs_after", 1'b0, 1'b1);
    chk_data("rs_after", 32'h0, 64'h0, 1'b0);
    send_one("rs_first", 3'b000, 32'h7FF00093, 32'h000007FF,
             64'h00000000000007FF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
